// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: clocked valid/ready wrapper around the combinational ripple ALU.
// Launches operands onto the ALU, waits SETTLE_CYCLES edges for the ripple
// to resolve, then captures and formats the result for a response handshake.
// Optional feature: define ALU_SEQ_ERR_EN to reject opcodes 001/011/110 with
// an immediate error response instead of running them through the ALU.
module alu_seq_ctrl #(
    parameter int SETTLE_CYCLES = 4   // 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_s1,
    output logic        alu_s2,
    output logic        alu_sub,
    output logic        alu_cin,
    input  logic [31:0] alu_f,
    input  logic        alu_cout,
    input  logic        alu_zero,
    input  logic        alu_set,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_cout,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept;
    logic        illegal;
    logic        capture;
    logic [2:0]  cur_op;
    logic        cur_slt;
    logic [31:0] fmt_result;
    logic        fmt_zero;
    logic        fmt_cout;

    assign alu_cin = 1'b0;
    assign accept  = req_valid & req_ready;
    assign capture = (state == SETTLE) && (cnt == 4'd0);

`ifdef ALU_SEQ_ERR_EN
    assign illegal = (req_op == 3'b001) || (req_op == 3'b011) || (req_op == 3'b110);
`else
    assign illegal = 1'b0;
`endif

    // Format from the launched select lines, not from req_op (don't-care by now).
    // For SLT the flag is the only meaningful bit, so zero follows ~set.
    assign cur_op     = {alu_s1, alu_s2, alu_sub};
    assign cur_slt    = (cur_op == 3'b111);
    assign fmt_result = cur_slt ? {31'b0, alu_set} : alu_f;
    assign fmt_zero   = cur_slt ? ~alu_set : alu_zero;
    assign fmt_cout   = ((cur_op == 3'b100) || (cur_op == 3'b101)) ? alu_cout : 1'b0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake ready.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = illegal ? DONE : SETTLE;
            end
            SETTLE: if (cnt == 4'd0) state_nxt = DONE;
            DONE:   if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Settle countdown: loaded on accept, decremented until zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               cnt <= 4'd0;
        else if (accept)                       cnt <= 4'(SETTLE_CYCLES - 1);
        else if (state == SETTLE && cnt != 0)  cnt <= cnt - 4'd1;
    end

    // ALU launch registers; only a legal accept moves them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_s1  <= 1'b0;
            alu_s2  <= 1'b0;
            alu_sub <= 1'b0;
        end else if (accept && !illegal) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_s1  <= req_op[2];
            alu_s2  <= req_op[1];
            alu_sub <= req_op[0];
        end
    end

    // Response registers: captured at end of settle, or forced on an illegal accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_cout   <= 1'b0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= fmt_result;
            rsp_zero   <= fmt_zero;
            rsp_cout   <= fmt_cout;
        end else if (accept && illegal) begin
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_cout   <= 1'b0;
        end else if (state == DONE && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_SEQ_ERR_EN
    // Error flag tracks the opcode legality of the most recent accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rsp_err <= 1'b0;
        else if (accept) rsp_err <= illegal;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed + randomized checks of alu_seq_ctrl against a
// behavioural ALU and a reference model computed with plain integer arithmetic.
module tb_alu_seq_ctrl;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_a, alu_b, alu_f;
    logic        alu_s1, alu_s2, alu_sub, alu_cin;
    logic        alu_cout, alu_zero, alu_set;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] pa = '0, pb = '0;
    logic [2:0]  pop = '0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s1(alu_s1), .alu_s2(alu_s2),
        .alu_sub(alu_sub), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_set(alu_set),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
    );

    // Behavioural ripple ALU: b optionally inverted with carry-in = sub.
    logic [31:0] bx;
    logic [32:0] sum;
    logic        ovf;
    always_comb begin
        bx       = alu_sub ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, bx} + {32'b0, alu_sub};
        ovf      = (alu_a[31] == bx[31]) && (sum[31] != alu_a[31]);
        alu_set  = sum[31] ^ ovf;
        alu_cout = sum[32];
        case ({alu_s1, alu_s2})
            2'b00:   alu_f = alu_a & bx;
            2'b01:   alu_f = alu_a | bx;
            2'b10:   alu_f = sum[31:0];
            default: alu_f = {31'b0, alu_set};
        endcase
        alu_zero = (alu_f == 32'd0);
    end

    function automatic bit is_illegal(input logic [2:0] op);
`ifdef ALU_SEQ_ERR_EN
        return (op == 3'b001) || (op == 3'b011) || (op == 3'b110);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: expected response from opcode semantics in 64-bit integers.
    task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic z, output logic co,
                             output logic er);
        longint sa, sb, ua, ub;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        co = 1'b0; er = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a & ~b;
            3'b010: res = a | b;
            3'b011: res = a | ~b;
            3'b100: begin res = 32'(ua + ub); co = ((ua + ub) >> 32) != 0; end
            3'b101: begin res = 32'(ua - ub); co = (ua >= ub); end
            3'b110: res = (sa + sb < 0) ? 32'd1 : 32'd0;
            default: res = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        if (is_illegal(op)) begin res = '0; co = 1'b0; er = 1'b1; end
        z = (res == 32'd0);
    endtask

    // One full transaction; called and returns just after a falling edge.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int bp);
        logic [31:0] er_res, ea, eb;
        logic        ez, ec, ee;
        logic [2:0]  eop;
        int lat, exp_lat;
        ref_model(op, a, b, er_res, ez, ec, ee);
        if (is_illegal(op)) begin ea = pa; eb = pb; eop = pop; exp_lat = 0; end
        else begin ea = a; eb = b; eop = op; exp_lat = S; end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL %s req_ready at issue: got %b want 1", nm, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tests++;
            if ({alu_a, alu_b, alu_s1, alu_s2, alu_sub} !== {ea, eb, eop}) begin
                fails++; $display("FAIL %s alu launch: got %h %h %b want %h %h %b",
                                  nm, alu_a, alu_b, {alu_s1, alu_s2, alu_sub}, ea, eb, eop);
            end
            @(negedge clk); lat++;
        end
        tests++;
        if (lat != exp_lat) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
        end
        for (int i = 0; i <= bp; i++) begin
            if (i == bp) rsp_ready = 1'b1;
            tests++;
            if ({rsp_valid, req_ready, rsp_result, rsp_zero, rsp_cout, rsp_err} !==
                {1'b1, 1'b0, er_res, ez, ec, ee}) begin
                fails++; $display("FAIL %s response: got v=%b rdy=%b r=%h z=%b c=%b e=%b want v=1 rdy=0 r=%h z=%b c=%b e=%b",
                                  nm, rsp_valid, req_ready, rsp_result, rsp_zero, rsp_cout, rsp_err,
                                  er_res, ez, ec, ee);
            end
            tests++;
            if ({alu_a, alu_b, alu_s1, alu_s2, alu_sub} !== {ea, eb, eop}) begin
                fails++; $display("FAIL %s alu hold: got %h %h want %h %h", nm, alu_a, alu_b, ea, eb);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        tests++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            fails++; $display("FAIL %s consume: got v=%b rdy=%b want v=0 rdy=1", nm, rsp_valid, req_ready);
        end
        pa = ea; pb = eb; pop = eop;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        @(negedge clk); @(negedge clk);
        tests++;
        if ({req_ready, rsp_valid, alu_a, alu_b, alu_s1, alu_s2, alu_sub, alu_cin,
             rsp_result, rsp_zero, rsp_cout, rsp_err} !== {1'b1, 1'b0, 64'd0, 4'd0, 32'd0, 3'd0}) begin
            fails++; $display("FAIL reset state: rdy=%b v=%b a=%h b=%h r=%h", req_ready, rsp_valid,
                              alu_a, alu_b, rsp_result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op("add", 3'b100, 32'd2, 32'd3, 0);
        do_op("sub", 3'b101, 32'd3, 32'd3, 0);
        do_op("or", 3'b010, 32'd4, 32'd5, 0);
        do_op("slt_lt", 3'b111, 32'd2, 32'd7, 0);
        do_op("slt_ge", 3'b111, 32'd10, 32'd5, 0);
        do_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        do_op("add_wrap", 3'b100, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("slt_neg", 3'b111, 32'h8000_0000, 32'd0, 0);
    endtask

    task automatic test_backpressure();
        do_op("bp_add", 3'b100, 32'd5, 32'd4, 3);
    endtask

    task automatic test_illegal();
        do_op("illegal_011", 3'b011, 32'd4, 32'd5, 1);
        do_op("after_illegal", 3'b100, 32'd6, 32'd7, 0);
    endtask

    task automatic test_reset_mid_op();
        req_valid = 1'b1; req_op = 3'b100; req_a = 32'd7; req_b = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({req_ready, rsp_valid, alu_a, alu_b, alu_s1, alu_s2, alu_sub,
             rsp_result, rsp_zero, rsp_cout, rsp_err} !== {1'b1, 1'b0, 64'd0, 3'd0, 32'd0, 3'd0}) begin
            fails++; $display("FAIL mid reset: rdy=%b v=%b a=%h b=%h r=%h", req_ready, rsp_valid,
                              alu_a, alu_b, rsp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < S + 2; i++) begin
            tests++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                fails++; $display("FAIL post reset idle: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
            end
            @(negedge clk);
        end
        pa = '0; pb = '0; pop = '0;
        do_op("add_after_rst", 3'b100, 32'd1, 32'd1, 0);
    endtask

    task automatic test_random();
        logic [31:0] edges [4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom;
            b = ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom;
            if (i % 5 == 0) b = a;
            do_op("random", 3'($urandom_range(7)), a, b, $urandom_range(3));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
